// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the synchronous FIFO.
// Values come from MACRO.svh.
`include "MACRO.svh"

package fifo_pkg;
  localparam int DATA_WIDTH = `FIFO_DATA_WIDTH;
  localparam int DEPTH      = `FIFO_DEPTH;
  localparam int MARGIN     = `MARGIN;
  localparam int PTR_WIDTH  = `PTR_WIDTH;

  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_if.sv
// Bundled FIFO user-side signals.
// master drives requests, slave returns data and status.
interface fifo_if #(
  parameter int DW = fifo_pkg::DATA_WIDTH,
  parameter int PW = fifo_pkg::PTR_WIDTH
);
  logic          wr_en;
  logic [DW-1:0] wdata;
  logic          rd_en;
  logic [DW-1:0] rdata;
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          full;
  logic          empty;
  logic          almostfull;
  logic          almostempty;
  logic          overflow;
  logic          underflow;

  modport master (
    output wr_en, wdata, rd_en,
    input  rdata, wptr, rptr, full, empty,
    input  almostfull, almostempty,
    input  overflow, underflow
  );

  modport slave (
    input  wr_en, wdata, rd_en,
    output rdata, wptr, rptr, full, empty,
    output almostfull, almostempty,
    output overflow, underflow
  );
endinterface

// File: rtl/MACRO.svh
// Default build parameters shared by the FIFO package and bench.
// Define FIFO_ERR_FLAG_EN on the command line to enable sticky error flags.
`ifndef FIFO_MACRO_SVH
`define FIFO_MACRO_SVH
`define FIFO_DATA_WIDTH 8
`define FIFO_DEPTH 16
`define MARGIN 2
`define PTR_WIDTH 5
`endif

// File: rtl/fifo_mem.sv
// FIFO storage: register array, one write port, registered read port.
// Storage is never reset; rd_clr only zeroes the read register.
module fifo_mem #(
  parameter int DW    = fifo_pkg::DATA_WIDTH,
  parameter int DEPTH = fifo_pkg::DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic          rd_clr,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] rdata_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    unique case (1'b1)
      rd_clr:  rdata_d = '0;
      re:      rdata_d = mem_q[raddr];
      default: rdata_d = rdata_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q   <= mem_d;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;
endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: pointers, status flags and optional sticky errors.
// Define FIFO_ERR_FLAG_EN to enable overflow/underflow tracking.
module sync_fifo #(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int DEPTH      = fifo_pkg::DEPTH,
  parameter int MARGIN     = fifo_pkg::MARGIN,
  localparam int PTR_WIDTH = fifo_pkg::ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [PTR_WIDTH-1:0]  wptr,
  output logic [PTR_WIDTH-1:0]  rptr,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic                  overflow,
  output logic                  underflow
);
  localparam int AW = PTR_WIDTH - 1;

  logic [PTR_WIDTH-1:0] wptr_q;
  logic [PTR_WIDTH-1:0] wptr_d;
  logic [PTR_WIDTH-1:0] rptr_q;
  logic [PTR_WIDTH-1:0] rptr_d;
  logic [PTR_WIDTH-1:0] count;
  logic                 wr_acc;
  logic                 rd_acc;

  always_comb begin
    full   = (wptr_q[AW] != rptr_q[AW]) &&
             (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    empty  = (wptr_q == rptr_q);
    count  = wptr_q - rptr_q;
    wr_acc = rstn && wr_en && !full;
    rd_acc = rstn && rd_en && !empty;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (wr_acc) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (rd_acc) begin
      rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Margin of 0 (or a whole depth) collapses the almost flags onto full/empty
  if (MARGIN % DEPTH != 0) begin : g_almost
    assign almostfull  = (32'(count) == DEPTH - MARGIN);
    assign almostempty = (32'(count) == MARGIN);
  end else begin : g_exact
    assign almostfull  = full;
    assign almostempty = empty;
  end

  fifo_mem #(
    .DW    (DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk    (clk),
    .we     (wr_acc),
    .waddr  (wptr_q[AW-1:0]),
    .wdata  (wdata),
    .re     (rd_acc),
    .rd_clr (!rstn),
    .raddr  (rptr_q[AW-1:0]),
    .rdata  (rdata)
  );

`ifdef FIFO_ERR_FLAG_EN
  logic ovf_q;
  logic ovf_d;
  logic udf_q;
  logic udf_d;

  always_comb begin
    ovf_d = ovf_q | (wr_en && full);
    udf_d = udf_q | (rd_en && empty);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign wptr = wptr_q;
  assign rptr = rptr_q;
endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo (DEPTH=16, MARGIN=2, DATA_WIDTH=8).
// Driver pushes expected read data; a negedge monitor pops and compares.
module tb_sync_fifo;
  logic clk;
  logic rstn;

  fifo_if #(.DW(8), .PW(5)) bus ();

  sync_fifo #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .MARGIN     (2)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .wr_en       (bus.wr_en),
    .wdata       (bus.wdata),
    .rd_en       (bus.rd_en),
    .rdata       (bus.rdata),
    .wptr        (bus.wptr),
    .rptr        (bus.rptr),
    .full        (bus.full),
    .empty       (bus.empty),
    .almostfull  (bus.almostfull),
    .almostempty (bus.almostempty),
    .overflow    (bus.overflow),
    .underflow   (bus.underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0] mm [16];
  logic [4:0] m_w = '0;
  logic [4:0] m_r = '0;
  logic       m_ovf = 1'b0;
  logic       m_udf = 1'b0;
  logic [7:0] exp_q [$];
  logic [7:0] hold = '0;
  logic       rd_seen = 1'b0;
  logic       mon_on = 1'b0;
  logic       saw_wrap = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (rd_seen) begin
        if (exp_q.size() == 0) begin
          chk("sb_underrun", 32'd1, 32'd0);
        end else begin
          hold = exp_q.pop_front();
        end
      end
      chk("rdata", {24'h0, bus.rdata}, {24'h0, hold});
    end
  end

  task automatic check_state();
    logic [4:0] c;
    c = m_w - m_r;
    chk("wptr", {27'h0, bus.wptr}, {27'h0, m_w});
    chk("rptr", {27'h0, bus.rptr}, {27'h0, m_r});
    chk("full", {31'h0, bus.full}, {31'h0, c == 5'd16});
    chk("empty", {31'h0, bus.empty}, {31'h0, c == 5'd0});
    chk("almostfull", {31'h0, bus.almostfull}, {31'h0, c == 5'd14});
    chk("almostempty", {31'h0, bus.almostempty}, {31'h0, c == 5'd2});
    chk("overflow", {31'h0, bus.overflow}, {31'h0, m_ovf});
    chk("underflow", {31'h0, bus.underflow}, {31'h0, m_udf});
  endtask

  task automatic step(input logic we, input logic [7:0] wd,
                      input logic re);
    logic [4:0] c;
    logic       wa;
    logic       ra;
    logic [4:0] prev_w;
    bus.wr_en = we;
    bus.wdata = wd;
    bus.rd_en = re;
    c  = m_w - m_r;
    wa = we && (c != 5'd16);
    ra = re && (c != 5'd0);
`ifdef FIFO_ERR_FLAG_EN
    if (we && c == 5'd16) m_ovf = 1'b1;
    if (re && c == 5'd0) m_udf = 1'b1;
`endif
    if (ra) exp_q.push_back(mm[m_r[3:0]]);
    if (wa) mm[m_w[3:0]] = wd;
    if (wa) m_w = m_w + 5'd1;
    if (ra) m_r = m_r + 5'd1;
    prev_w = bus.wptr;
    @(posedge clk);
    rd_seen = ra;
    #1;
    if (prev_w == 5'h1F && bus.wptr == 5'h00) saw_wrap = 1'b1;
    check_state();
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    bus.wr_en = 1'b1;
    bus.wdata = 8'hEE;
    bus.rd_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      rd_seen = 1'b0;
      hold = 8'h00;
      exp_q.delete();
      m_w = '0;
      m_r = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end
    #1;
    check_state();
    rstn = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    bus.wr_en = 1'b0;
    bus.wdata = '0;
    bus.rd_en = 1'b0;
    do_reset(2);
    mon_on = 1'b1;
    chk("rst_rdata", {24'h0, bus.rdata}, 32'h0);
    chk("rst_empty", {31'h0, bus.empty}, 32'h1);
    chk("rst_ae", {31'h0, bus.almostempty}, 32'h0);

    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    chk("fill_wptr", {27'h0, bus.wptr}, 32'h10);
    chk("fill_full", {31'h0, bus.full}, 32'h1);
    step(1'b1, 8'hAA, 1'b0);
    chk("ovf_wptr", {27'h0, bus.wptr}, 32'h10);
`ifdef FIFO_ERR_FLAG_EN
    chk("ovf_flag", {31'h0, bus.overflow}, 32'h1);
`endif

    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_rptr", {27'h0, bus.rptr}, 32'h10);
    step(1'b0, 8'h00, 1'b1);
    chk("udf_rptr", {27'h0, bus.rptr}, 32'h10);
`ifdef FIFO_ERR_FLAG_EN
    chk("udf_flag", {31'h0, bus.underflow}, 32'h1);
`endif

    step(1'b1, 8'h20, 1'b1);
    for (int i = 1; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    chk("conc_w0", {27'h0, bus.wptr}, 32'h15);
    for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h30 + i), 1'b1);
    chk("conc_w3", {27'h0, bus.wptr}, 32'h18);
    chk("conc_r3", {27'h0, bus.rptr}, 32'h13);

    for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h40 + i), 1'b1);
    chk("wrap_w", {27'h0, bus.wptr}, 32'h00);
    chk("wrap_r", {27'h0, bus.rptr}, 32'h1B);
    chk("wrap_seen", {31'h0, saw_wrap}, 32'h1);

    step(1'b1, 8'h70, 1'b0);
    step(1'b1, 8'h71, 1'b0);
    chk("pre_rst_w", {27'h0, bus.wptr}, 32'h02);
    do_reset(1);
    chk("mid_rst_w", {27'h0, bus.wptr}, 32'h0);
    chk("mid_rst_empty", {31'h0, bus.empty}, 32'h1);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    chk("post_rst_rdata", {24'h0, bus.rdata}, 32'h5A);

    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b1, 8'hBB, 1'b1);
    chk("full_rw_w", {27'h0, bus.wptr}, 32'h11);
    chk("full_rw_r", {27'h0, bus.rptr}, 32'h02);
    step(1'b0, 8'h00, 1'b0);
    chk("full_rw_data", {24'h0, bus.rdata}, 32'h80);
    step(1'b0, 8'h00, 1'b0);
    chk("sb_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL take parameter DATA_WIDTH, default 8, payload width in bits.
REQ-002 The block SHALL take parameter DEPTH, default `FIFO_DEPTH (16), entry count, power of two >= 4.
REQ-003 The block SHALL take parameter MARGIN, default `MARGIN (2), almost-flag distance in entries.
REQ-004 The block SHALL derive PTR_WIDTH = $clog2(DEPTH)+1, equal to `PTR_WIDTH.
REQ-005 Ports SHALL be, in this order:
  clk  in  1  the single clock; every flop is rising-edge clocked.
  rstn  in  1  reset, synchronous to clk, active-low.
  wr_en  in  1  write request.
  wdata  in  DATA_WIDTH  write payload.
  rd_en  in  1  read request.
  rdata  out  DATA_WIDTH  registered read payload.
  wptr  out  PTR_WIDTH  write pointer; MSB is the wrap bit.
  rptr  out  PTR_WIDTH  read pointer; MSB is the wrap bit.
  full, empty, almostfull, almostempty  out  1 each  status flags.
  overflow, underflow  out  1 each  sticky error flags.

Function
REQ-006 A write SHALL be accepted at a clk edge iff wr_en && !full; mem[wptr[PTR_WIDTH-2:0]] <= wdata and wptr <= wptr+1.
REQ-007 A read SHALL be accepted at a clk edge iff rd_en && !empty; rdata <= mem[rptr[PTR_WIDTH-2:0]] and rptr <= rptr+1, giving one-cycle read latency.
REQ-008 rdata SHALL hold its value in cycles with no accepted read.
REQ-009 Pointers SHALL wrap modulo 2^PTR_WIDTH (e.g. 5'h1F -> 5'h00); wrap SHALL toggle the MSB only.
REQ-010 full SHALL equal (wptr MSB != rptr MSB) && (lower bits equal), driven combinationally from the registered pointers.
REQ-011 empty SHALL equal (wptr == rptr), driven combinationally from the registered pointers.
REQ-012 If MARGIN%DEPTH != 0, almostfull SHALL be 1 iff count == DEPTH-MARGIN, where count = wptr-rptr; otherwise almostfull SHALL equal full.
REQ-013 If MARGIN%DEPTH != 0, almostempty SHALL be 1 iff count == MARGIN; otherwise almostempty SHALL equal empty.
REQ-014 A simultaneous write and read SHALL both be accepted when neither full nor empty; count is then unchanged.
REQ-015 When full, a simultaneous write SHALL be dropped and the read SHALL proceed.
REQ-016 When empty, a simultaneous read SHALL be dropped and the write SHALL proceed; there is no fall-through.
REQ-017 A dropped request SHALL change neither pointers nor memory.

Reset
REQ-018 While rstn == 0 at a clk edge, the block SHALL set wptr = 0, rptr = 0, rdata = 0, overflow = 0 and underflow = 0.
REQ-019 During reset, flags SHALL follow REQ-010..013: empty=1, full=0, almostfull=0; almostempty = (MARGIN%DEPTH == 0).
REQ-020 Reset SHALL take priority over wr_en and rd_en, and a mid-operation reset SHALL discard all stored entries.
REQ-021 Memory contents SHALL NOT be cleared by reset.

Configuration
REQ-022 With FIFO_ERR_FLAG_EN defined, overflow SHALL set on (wr_en && full) and underflow SHALL set on (rd_en && empty); each SHALL remain set until reset.
REQ-023 Without FIFO_ERR_FLAG_EN, overflow and underflow SHALL be tied 0 and the sticky logic SHALL be absent.

Structure
REQ-024 Package fifo_pkg SHALL hold DATA_WIDTH, DEPTH, MARGIN and PTR_WIDTH defaults, sourced from MACRO.svh.
REQ-025 Storage SHALL be a sub-module fifo_mem: DEPTH x DATA_WIDTH register array, one write port, one registered read port, no reset.
REQ-026 Pointer, flag and error logic SHALL reside in sync_fifo.

Verification (DEPTH=16, MARGIN=2, DATA_WIDTH=8)
REQ-027 Reset test: hold rstn=0 for 2 cycles -> wptr=rptr=0, empty=1, full=almostfull=almostempty=0, rdata=0.
REQ-028 Fill test: write 0x00..0x0F -> almostempty=1 at count 2, almostfull=1 at count 14, full=1 with wptr=5'h10 at count 16; 17th write leaves wptr=5'h10, overflow=1 (with macro).
REQ-029 Drain test: read 16 entries -> rdata 0x00..0x0F in order, each one cycle after its accept; empty=1 with rptr=5'h10; an extra read sets underflow=1 (with macro).
REQ-030 Concurrency test: at count 5, assert wr_en and rd_en for 3 cycles -> count stays 5, each pointer advances by 3.
REQ-031 Wrap test: interleave 40 writes and reads -> pointers pass 5'h1F->5'h00, data order preserved, no full/empty false flag.
REQ-032 Mid-operation reset: at count 7 pull rstn=0 for one cycle -> next edge wptr=rptr=0, empty=1; a subsequent write/read returns the new data.
